// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Requests an instruction word at the current PC, holds it in the
// instruction register until decode accepts it, then advances the PC
// (sequentially or to a taken branch target) and counts the accepted
// instructions.
//
// Build option: MISALIGN_TRAP_EN
//   defined   - a taken redirect to a non word-aligned target loads the PC,
//               raises fetch_fault and parks the unit in FAULT until reset.
//   undefined - the low two bits of the target are cleared, fetch_fault is
//               tied low and the FAULT state is not built.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  // instruction memory port
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  // decode-side handshake
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic        IRWrite,
  output logic        PCEn,
  output logic [31:0] pc_out,
  // redirect request
  input  logic        Branch,
  input  logic        Cond_Chk,
  input  logic [31:0] branch_target,
  // status
  output logic [31:0] instr_count,
  output logic        fetch_fault
);

  // Encoded FSM states. S_FAULT is only reachable with the trap enabled;
  // without it the encoding is simply unused and decodes back to IDLE.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  // Instruction register value after reset: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        irwrite_q, irwrite_d;
  logic [31:0] count_q, count_d;

  logic        handshake;
  logic        redirect;
  logic [31:0] target_eff;
  logic [31:0] pc_seq;

  // Handshake and redirect qualification; the redirect inputs only matter
  // when decode actually takes the instruction.
  assign handshake = (state_q == S_HOLD) && decode_ready;
  assign redirect  = Branch && Cond_Chk;
  assign pc_seq    = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic misaligned;

  // Target is used verbatim; misalignment is trapped instead of repaired.
  assign target_eff  = branch_target;
  assign misaligned  = (branch_target[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  // Without the trap, a misaligned target is silently word-aligned.
  assign target_eff  = branch_target & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif

  // Externally visible signals decode directly from registered state.
  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = pc_q;
  assign pc_out      = pc_q;
  assign instruction = ir_q;
  assign instr_valid = (state_q == S_HOLD);
  assign IRWrite     = irwrite_q;
  assign instr_count = count_q;
  assign PCEn        = handshake;

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    irwrite_d = 1'b0;
    count_d   = count_q;
`ifdef MISALIGN_TRAP_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // Memory data is only captured here; elsewhere it is ignored.
        if (mem_ready) begin
          ir_d      = mem_rdata;
          irwrite_d = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (decode_ready) begin
          count_d = count_q + 32'd1;
          state_d = S_REQ;
          if (redirect) begin
            pc_d = target_eff;
`ifdef MISALIGN_TRAP_EN
            if (misaligned) begin
              state_d = S_FAULT;
              fault_d = 1'b1;
            end
`endif
          end else begin
            pc_d = pc_seq;
          end
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_FAULT: begin
        // Parked until reset: no requests, nothing presented to decode.
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every same-cycle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      irwrite_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      irwrite_q <= irwrite_d;
      count_q   <= count_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a scoreboard of
// fetched words. Each memory response pushes {pc, word}; each decode
// handshake pops it and compares against the DUT's instruction and PC.
module tb_fetch_unit;

  localparam logic [31:0] RP  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        decode_ready;
  logic        IRWrite;
  logic        PCEn;
  logic [31:0] pc_out;
  logic        Branch;
  logic        Cond_Chk;
  logic [31:0] branch_target;
  logic [31:0] instr_count;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } sb_t;

  sb_t         sb_q[$];
  int          total;
  int          bad;
  logic [31:0] model_pc;
  logic [31:0] model_cnt;

  fetch_unit #(.RESET_PC(RP)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .IRWrite       (IRWrite),
    .PCEn          (PCEn),
    .pc_out        (pc_out),
    .Branch        (Branch),
    .Cond_Chk      (Cond_Chk),
    .branch_target (branch_target),
    .instr_count   (instr_count),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one memory read while the DUT is in REQ.
  task automatic fetch(input logic [31:0] data);
    mem_ready = 1'b1;
    mem_rdata = data;
    #1;
    chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_mem_addr", mem_addr, model_pc);
    sb_q.push_back('{pc: model_pc, ins: data});
    $display("fetch    addr=%h data=%h", mem_addr, data);
    tick();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
    chk("fetch_mem_req_off", {31'd0, mem_req}, 32'd0);
  endtask

  // Hand the held instruction to decode with the given redirect inputs.
  task automatic accept(input logic br, input logic cond, input logic [31:0] tgt);
    sb_t e;
    Branch        = br;
    Cond_Chk      = cond;
    branch_target = tgt;
    decode_ready  = 1'b1;
    #1;
    chk("accept_pcen", {31'd0, PCEn}, 32'd1);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_instruction", instruction, e.ins);
      chk("sb_pc", pc_out, e.pc);
    end
    tick();
    decode_ready = 1'b0;
    Branch       = 1'b0;
    Cond_Chk     = 1'b0;
    model_cnt    = model_cnt + 32'd1;
`ifdef MISALIGN_TRAP_EN
    model_pc = (br && cond) ? tgt : model_pc + 32'd4;
`else
    model_pc = (br && cond) ? (tgt & 32'hFFFF_FFFC) : model_pc + 32'd4;
`endif
    chk("accept_pc", pc_out, model_pc);
    chk("accept_count", instr_count, model_cnt);
    chk("accept_pcen_off", {31'd0, PCEn}, 32'd0);
    $display("accept   br=%0b cond=%0b tgt=%h -> pc=%h count=%0d", br, cond, tgt, pc_out, instr_count);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    model_pc      = RP;
    model_cnt     = 32'd0;
    reset         = 1'b1;
    mem_ready     = 1'b1;
    mem_rdata     = 32'h002A_5A33;
    decode_ready  = 1'b0;
    Branch        = 1'b0;
    Cond_Chk      = 1'b0;
    branch_target = 32'd0;

    // Reset state.
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
    chk("rst_pc", pc_out, RP);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    $display("reset    pc=%h instr=%h", pc_out, instruction);

    // Release with mem_ready held high: REQ on the 2nd cycle, IR on the 3rd.
    reset = 1'b0;
    tick();
    fetch(32'h002A_5A33);

    // Stall decode for five cycles total.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_irwrite", {31'd0, IRWrite}, 32'd0);
      chk("stall_pc", pc_out, 32'd0);
      chk("stall_instr", instruction, 32'h002A_5A33);
    end
    accept(1'b0, 1'b0, 32'd0);
    chk("next_req", {31'd0, mem_req}, 32'd1);

    // decode_ready without a valid instruction changes nothing.
    decode_ready = 1'b1;
    #1;
    chk("idle_ready_pcen", {31'd0, PCEn}, 32'd0);
    tick();
    decode_ready = 1'b0;
    chk("idle_ready_pc", pc_out, model_pc);
    chk("idle_ready_count", instr_count, model_cnt);

    // Redirect inputs ignored outside a handshake; then not-taken branch.
    fetch(32'h1111_1111);
    Branch        = 1'b1;
    Cond_Chk      = 1'b1;
    branch_target = 32'h0000_0500;
    tick();
    chk("ignored_branch_pc", pc_out, model_pc);
    chk("ignored_branch_valid", {31'd0, instr_valid}, 32'd1);
    accept(1'b1, 1'b0, 32'h0000_0200);

    // Taken branch, then PC wrap at the top of the address space.
    fetch(32'h2222_2222);
    accept(1'b1, 1'b1, 32'h0000_0100);
    fetch(32'h3333_3333);
    accept(1'b1, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h4444_4444);
    accept(1'b0, 1'b1, 32'h0000_0700);
    chk("wrap_pc", pc_out, 32'h0000_0000);

    // Reset beats a same-cycle handshake.
    fetch(32'h5555_5555);
    reset        = 1'b1;
    decode_ready = 1'b1;
    tick();
    reset        = 1'b0;
    decode_ready = 1'b0;
    sb_q.delete();
    model_pc  = RP;
    model_cnt = 32'd0;
    chk("rst_hs_count", instr_count, 32'd0);
    chk("rst_hs_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_hs_instr", instruction, NOP);
    $display("reset    during handshake pc=%h", pc_out);

    // Reset during REQ with mem_ready in the same cycle, late mem_ready after.
    tick();
    chk("req_again", {31'd0, mem_req}, 32'd1);
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    chk("rst_req_instr", instruction, NOP);
    chk("rst_req_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req_pc", pc_out, RP);
    tick();
    mem_ready = 1'b0;
    chk("late_ready_instr", instruction, NOP);
    chk("late_ready_valid", {31'd0, instr_valid}, 32'd0);
    $display("reset    during fetch instr=%h", instruction);

    // Misaligned taken redirect.
    fetch(32'h6666_6666);
    accept(1'b1, 1'b1, 32'h0000_0102);
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("fault_flag", {31'd0, fetch_fault}, 32'd1);
      chk("fault_mem_req", {31'd0, mem_req}, 32'd0);
      chk("fault_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
`else
    chk("align_fault", {31'd0, fetch_fault}, 32'd0);
    fetch(32'h7777_7777);
    chk("align_addr_hold", pc_out, 32'h0000_0100);
`endif
    $display("misalign pc=%h fault=%0b", pc_out, fetch_fault);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
